// File: rtl/frame_readout.sv
// frame_readout: reads frame SRAM words 0..last_addr and streams each word
// as four LSB-first bytes on a valid/ready interface.
module frame_readout #(
    parameter int RD_LAT = 2,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] last_addr,
    output logic          s1_RE,
    output logic [AW-1:0] s1_Addr,
    input  logic [31:0]   s1_RD,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);
    localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, WAIT = 3'd2, SEND = 3'd3, FIN = 3'd4;

    logic [2:0]    state, cnt;
    logic [1:0]    idx;
    logic [31:0]   word;
    logic [AW-1:0] addr, lim;
    logic          hs;

    assign hs       = tx_valid && tx_ready;
    assign s1_RE    = state != RD;
    assign s1_Addr  = addr;
    assign tx_valid = state == SEND;
    assign busy     = (state == RD) || (state == WAIT) || (state == SEND);
    assign done     = state == FIN;
    assign tx_data  = idx == 2'd0 ? word[7:0] :
                      idx == 2'd1 ? word[15:8] :
                      idx == 2'd2 ? word[23:16] : word[31:24];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            word  <= '0;
            addr  <= '0;
            lim   <= '0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    lim   <= last_addr;
                    addr  <= '0;
                    idx   <= '0;
                    state <= RD;
                end
                RD: begin
                    cnt   <= 3'd1;
                    state <= WAIT;
                end
                // cnt counts cycles since the RE-low cycle; data is valid when it reaches RD_LAT
                WAIT: if (cnt == 3'(RD_LAT)) begin
                    word  <= s1_RD;
                    idx   <= '0;
                    state <= SEND;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                SEND: if (hs) begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        if (addr == lim) begin
                            state <= FIN;
                        end else begin
                            addr  <= addr + AW'(1);
                            state <= RD;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_readout.sv
// tb_frame_readout: directed checks of frame_readout at RD_LAT 2, 1 and 7
// against a latency-accurate SRAM model.
module tb_frame_readout;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, abort, tx_ready;
    logic [17:0] last_addr;
    logic [31:0] mem [0:15];

    logic        re_v [3];
    logic [17:0] addr_v [3];
    logic [31:0] rd_v [3];
    logic        tv_v [3];
    logic [7:0]  td_v [3];
    logic        busy_v [3];
    logic        done_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 7;
        logic [31:0] pipe [0:7];
        // data outside the read window is poisoned so a mistimed capture shows up
        always @(posedge clk) begin
            pipe[0] <= re_v[g] ? 32'hDEADBEEF : mem[addr_v[g][3:0]];
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
        assign rd_v[g] = pipe[LAT-1];
        frame_readout #(.RD_LAT(LAT), .AW(18)) dut (
            .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
            .last_addr(last_addr), .s1_RE(re_v[g]), .s1_Addr(addr_v[g]),
            .s1_RD(rd_v[g]), .tx_valid(tv_v[g]), .tx_data(td_v[g]),
            .tx_ready(tx_ready), .busy(busy_v[g]), .done(done_v[g])
        );
    end

    int total = 0, bad = 0;
    logic [7:0]  got [0:63];
    int          hs_cyc [0:63];
    logic [17:0] re_addr [0:15];
    logic        v_hist [0:63];
    logic        b_hist [0:63];
    logic [7:0]  st_data [0:7];
    logic        st_valid [0:7];
    int ngot, nre, ndone, done_cyc, first_re, first_v, nst;

    task automatic kick(input logic [17:0] la);
        @(negedge clk);
        last_addr = la;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // cycle c=1 is the cycle after the start pulse; outputs sampled mid-cycle
    task automatic collect(input int d, input int ncyc, input int stall_idx, input int stall_len,
                           input int start_at, input int abort_at);
        ngot = 0; nre = 0; ndone = 0; done_cyc = -1; first_re = -1; first_v = -1; nst = 0;
        for (int c = 1; c <= ncyc; c++) begin
            start = (c == start_at);
            abort = (c == abort_at);
            if (ngot == stall_idx && nst < stall_len && (nst > 0 || tv_v[d])) begin
                tx_ready = 1'b0;
                st_data[nst] = td_v[d];
                st_valid[nst] = tv_v[d];
                nst++;
            end else tx_ready = 1'b1;
            if (c < 64) begin v_hist[c] = tv_v[d]; b_hist[c] = busy_v[d]; end
            if (!re_v[d]) begin
                if (nre < 16) re_addr[nre] = addr_v[d];
                if (first_re < 0) first_re = c;
                nre++;
            end
            if (tv_v[d] && first_v < 0) first_v = c;
            if (tv_v[d] && tx_ready) begin
                if (ngot < 64) begin got[ngot] = td_v[d]; hs_cyc[ngot] = c; end
                ngot++;
            end
            if (done_v[d]) begin ndone++; done_cyc = c; end
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (re_v[0] !== 1'b1) begin bad++; $display("FAIL reset_re got=%b exp=1", re_v[0]); end
        total++; if (addr_v[0] !== 18'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr_v[0]); end
        total++; if (tv_v[0] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", tv_v[0]); end
        total++; if (td_v[0] !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", td_v[0]); end
        total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_v[0]); end
        total++; if (done_v[0] !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_v[0]); end
        reset_n = 1'b1;
    endtask

    task automatic test_single(input string nm);
        logic [31:0] w;
        int nb;
        w = 32'h44332211;
        mem[0] = w;
        kick(18'd0);
        collect(0, 45, -1, 0, -1, -1);
        total++; if (nre !== 1 || first_re !== 1 || re_addr[0] !== 18'd0) begin bad++;
            $display("FAIL %s_read got=n%0d c%0d a%0h exp=n1 c1 a0", nm, nre, first_re, re_addr[0]); end
        total++; if (ngot !== 4) begin bad++; $display("FAIL %s_count got=%0d exp=4", nm, ngot); end
        for (int k = 0; k < 4; k++) begin
            total++; if (got[k] !== w[8*k +: 8] || hs_cyc[k] !== 4 + k) begin bad++;
                $display("FAIL %s_byte%0d got=%h@%0d exp=%h@%0d", nm, k, got[k], hs_cyc[k], w[8*k +: 8], 4 + k); end
        end
        total++; if (ndone !== 1 || done_cyc !== 8) begin bad++;
            $display("FAIL %s_done got=n%0d c%0d exp=n1 c8", nm, ndone, done_cyc); end
        nb = 0;
        for (int c = 1; c < 46; c++) nb += int'(b_hist[c]);
        total++; if (nb !== 7 || b_hist[1] !== 1'b1 || b_hist[8] !== 1'b0) begin bad++;
            $display("FAIL %s_busy got=n%0d b1=%b b8=%b exp=n7 b1=1 b8=0", nm, nb, b_hist[1], b_hist[8]); end
    endtask

    task automatic test_multi;
        mem[0] = 32'h03020100; mem[1] = 32'h07060504; mem[2] = 32'h0B0A0908;
        kick(18'd2);
        collect(0, 45, -1, 0, -1, -1);
        total++; if (ngot !== 12) begin bad++; $display("FAIL multi_count got=%0d exp=12", ngot); end
        for (int k = 0; k < 12; k++) begin
            total++; if (got[k] !== 8'(k)) begin bad++; $display("FAIL multi_byte%0d got=%h exp=%h", k, got[k], 8'(k)); end
        end
        total++; if (nre !== 3) begin bad++; $display("FAIL multi_nre got=%0d exp=3", nre); end
        for (int k = 0; k < 3; k++) begin
            total++; if (re_addr[k] !== 18'(k)) begin bad++; $display("FAIL multi_addr%0d got=%h exp=%h", k, re_addr[k], k); end
        end
        total++; if (ndone !== 1 || done_cyc !== 22) begin bad++;
            $display("FAIL multi_done got=n%0d c%0d exp=n1 c22", ndone, done_cyc); end
    endtask

    task automatic test_backpressure;
        logic [31:0] w;
        w = 32'h44332211;
        mem[0] = w;
        kick(18'd0);
        collect(0, 45, 1, 5, -1, -1);
        total++; if (ngot !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", ngot); end
        for (int k = 0; k < 4; k++) begin
            total++; if (got[k] !== w[8*k +: 8]) begin bad++; $display("FAIL bp_byte%0d got=%h exp=%h", k, got[k], w[8*k +: 8]); end
        end
        total++; if (nst !== 5) begin bad++; $display("FAIL bp_stalls got=%0d exp=5", nst); end
        for (int k = 0; k < 5; k++) begin
            total++; if (st_data[k] !== 8'h22 || st_valid[k] !== 1'b1) begin bad++;
                $display("FAIL bp_hold%0d got=%h/%b exp=22/1", k, st_data[k], st_valid[k]); end
        end
        total++; if (nre !== 1) begin bad++; $display("FAIL bp_nre got=%0d exp=1", nre); end
        total++; if (ndone !== 1 || done_cyc !== 13) begin bad++;
            $display("FAIL bp_done got=n%0d c%0d exp=n1 c13", ndone, done_cyc); end
    endtask

    task automatic test_abort;
        mem[0] = 32'h03020100; mem[1] = 32'h07060504; mem[2] = 32'h0B0A0908;
        kick(18'd2);
        collect(0, 45, -1, 0, 5, 12);
        total++; if (ngot !== 6 || got[4] !== 8'h04 || got[5] !== 8'h05) begin bad++;
            $display("FAIL abort_bytes got=n%0d %h %h exp=n6 04 05", ngot, got[4], got[5]); end
        total++; if (v_hist[13] !== 1'b0 || b_hist[13] !== 1'b0) begin bad++;
            $display("FAIL abort_idle got=v%b b%b exp=v0 b0", v_hist[13], b_hist[13]); end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", ndone); end
        total++; if (nre !== 2) begin bad++; $display("FAIL abort_nre got=%0d exp=2", nre); end
        kick(18'd0);
        collect(0, 30, -1, 0, -1, -1);
        total++; if (ngot !== 4 || got[0] !== 8'h00 || got[3] !== 8'h03 || re_addr[0] !== 18'd0) begin bad++;
            $display("FAIL abort_restart got=n%0d %h %h a%h exp=n4 00 03 a0", ngot, got[0], got[3], re_addr[0]); end
        total++; if (ndone !== 1) begin bad++; $display("FAIL abort_restart_done got=%0d exp=1", ndone); end
    endtask

    task automatic test_reset_wait;
        mem[0] = 32'h44332211;
        kick(18'd0);
        collect(0, 1, -1, 0, -1, -1);
        reset_n = 1'b0;
        #1;
        total++; if (re_v[0] !== 1'b1 || tv_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin bad++;
            $display("FAIL rstwait got=re%b v%b b%b exp=re1 v0 b0", re_v[0], tv_v[0], busy_v[0]); end
        @(negedge clk);
        reset_n = 1'b1;
        test_single("rstwait");
    endtask

    task automatic test_latency(input int d, input int lat);
        mem[0] = 32'h13121110; mem[1] = 32'h17161514;
        kick(18'd1);
        collect(d, 45, -1, 0, -1, -1);
        total++; if (ngot !== 8) begin bad++; $display("FAIL lat%0d_count got=%0d exp=8", lat, ngot); end
        for (int k = 0; k < 8; k++) begin
            total++; if (got[k] !== 8'(16 + k)) begin bad++;
                $display("FAIL lat%0d_byte%0d got=%h exp=%h", lat, k, got[k], 8'(16 + k)); end
        end
        total++; if (first_v - first_re !== lat + 1) begin bad++;
            $display("FAIL lat%0d_first got=%0d exp=%0d", lat, first_v - first_re, lat + 1); end
        total++; if (ndone !== 1) begin bad++; $display("FAIL lat%0d_done got=%0d exp=1", lat, ndone); end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1; last_addr = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset;
        test_single("single");
        test_multi;
        test_backpressure;
        test_abort;
        test_reset_wait;
        test_latency(1, 1);
        test_latency(2, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
